irq_ctrl_ad48: RTL and testbench
================================

Name: irq_ctrl_ad48

Overview:
Interrupt controller that sits in front of the `cpu_ad48` core's `irq` interface. It is the responder side of the core's interrupt lines.
- Latches peripheral event lines into pending bits and masks them with per-line enables.
- Selects the highest-priority line and presents one request plus ID to the core.
- Tracks claim/complete through ack and end-of-interrupt (EOI) handshakes.
- Software configures it through a small register port mapped into AD48 data space.

Parameters:
IRQ_LINES, 4, number of interrupt sources (1..16); index 0 is highest priority.
ID_W, 4, width of irq_id; must satisfy 2**ID_W >= IRQ_LINES.

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous, active-low reset
src  in  IRQ_LINES  peripheral event lines, synchronous to clk unless IRQ_SYNC_EN
cfg_we  in  1  register write strobe
cfg_addr  in  2  register select: 0 PENDING, 1 ENABLE, 2 EDGE, 3 STATUS
cfg_wdata  in  IRQ_LINES  write data
cfg_rdata  out  IRQ_LINES  combinational read data for cfg_addr
irq_req  out  1  request to core
irq_id  out  ID_W  ID of the requested/in-service line
irq_ack  in  1  one-cycle pulse: core claims the current request
irq_eoi  in  1  one-cycle pulse: core finished servicing

Behaviour:
- Reset (async, resetn=0): PENDING=0, ENABLE=0, EDGE=0, state=IDLE, irq_req=0, irq_id=0, src history=0.
- Register map:
  - EDGE[i]=1 makes line i edge-triggered: PENDING[i] sets on a rising edge of src[i] (src_q[i]=0, src[i]=1).
  - EDGE[i]=0 makes line i level-triggered: PENDING[i] is loaded each cycle from src[i].
  - PENDING write is write-1-to-clear; it affects edge lines only. Level lines ignore it.
  - ENABLE and EDGE are plain read/write.
  - STATUS read = {zero-pad, in_service, irq_req, irq_id}; writes are ignored.
- Same-cycle conflict: when an edge sets a bit and a W1C or ack clears it in the same cycle, set wins.
- Eligible vector = PENDING & ENABLE. Priority encoder returns the lowest set index.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: when eligible != 0, next edge goes to REQ, irq_req<=1, irq_id<=encoder output.
  - REQ:
    - irq_id is frozen while in REQ.
    - irq_ack=1: go to SERVICE, irq_req<=0, clear PENDING[irq_id] if it is an edge line.
    - Else if eligible[irq_id]=0 (disabled or cleared): withdraw. Go to IDLE, irq_req<=0.
    - A newly pending higher-priority line does not preempt a pending request.
  - SERVICE: no new request (no nesting). irq_id keeps the serviced ID. irq_eoi=1 goes to IDLE.
- Ignored inputs: irq_ack outside REQ; irq_eoi outside SERVICE.
- Latency, no sync: src rise sampled at edge E0 → PENDING set after E0 → irq_req high after E1 (2 cycles). After EOI, a still-eligible line re-requests after 1 more cycle.
- Level line still asserted at EOI: re-requests. This is intended.
- Reset mid-operation: everything returns to the reset values immediately.

Optional Feature:
IRQ_SYNC_EN:
- Defined: src passes through a 2-flop synchronizer per line before edge/level detection. src→irq_req becomes 4 cycles. Synchronizer flops reset to 0.
- Undefined: src is used directly, with 2-cycle latency.

Decomposition:
- Package irq_ad48_pkg holds:
  - register address constants REG_PENDING/REG_ENABLE/REG_EDGE/REG_STATUS;
  - FSM state typedef/encoding (IDLE=0, REQ=1, SERVICE=2);
  - STATUS field offsets.
- One sub-module, irq_prio_enc: combinational, parameterised by IRQ_LINES/ID_W. Outputs any_valid and the lowest-set index.

Test Plan:
- Edge basics: EDGE=4'hF, ENABLE=4'h4, pulse src[2] one cycle → irq_req=1, irq_id=2 two cycles later. ack → PENDING=0, STATUS.in_service=1. eoi → IDLE, irq_req stays 0.
- Priority: ENABLE=4'hF, src[3] and src[1] rise together → irq_id=1. Ack+eoi → next request irq_id=3.
- Withdrawal: while REQ on id 0, write ENABLE=0 → irq_req=0 next cycle, state IDLE, PENDING[0] still 1.
- Level line: EDGE=0, ENABLE=1, hold src[0]=1 through ack/eoi → re-request 1 cycle after eoi. Drop src[0] → PENDING[0]=0 next cycle, no request.
- Conflicts: W1C PENDING[1] in the same cycle src[1] rises → PENDING[1]=1. irq_eoi in IDLE and irq_ack in SERVICE → no state change.
- Async reset asserted mid-SERVICE → irq_req=0 and all registers=0 without a clock edge. With IRQ_SYNC_EN, the edge-basics case shows 4-cycle latency.

Source files
------------

// File: rtl/irq_ad48_pkg.sv
// Shared constants for the AD48 interrupt controller: register map,
// FSM state encoding and STATUS field offsets.
package irq_ad48_pkg;

   localparam logic [1:0] REG_PENDING = 2'd0;
   localparam logic [1:0] REG_ENABLE  = 2'd1;
   localparam logic [1:0] REG_EDGE    = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_e;

   // STATUS = {zero-pad, in_service, irq_req, irq_id}; offsets of the
   // flag bits are relative to ID_W (irq_id occupies the low ID_W bits).
   localparam int STAT_REQ_REL   = 0;
   localparam int STAT_INSVC_REL = 1;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module irq_prio_enc #(
   parameter int IRQ_LINES = 4,
   parameter int ID_W      = 4
) (
   input  logic [IRQ_LINES-1:0] req_i,
   output logic                 any_valid_o,
   output logic [ID_W-1:0]      idx_o
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      any_valid_o = |req_i;
      idx_o       = '0;
      for (int i = IRQ_LINES - 1; i >= 0; i--) begin
         if (req_i[i]) idx_o = ID_W'(i);
      end
   end

endmodule

// File: rtl/irq_ctrl_ad48.sv
// Interrupt controller in front of the cpu_ad48 irq interface.
// Optional build macro: IRQ_SYNC_EN adds a 2-flop synchronizer per src line.
module irq_ctrl_ad48
   import irq_ad48_pkg::*;
#(
   parameter int IRQ_LINES = 4,
   parameter int ID_W      = 4
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [IRQ_LINES-1:0] src,
   input  logic                 cfg_we,
   input  logic [1:0]           cfg_addr,
   input  logic [IRQ_LINES-1:0] cfg_wdata,
   output logic [IRQ_LINES-1:0] cfg_rdata,
   output logic                 irq_req,
   output logic [ID_W-1:0]      irq_id,
   input  logic                 irq_ack,
   input  logic                 irq_eoi
);

   // state      | meaning
   // ST_IDLE    | no request outstanding, waiting for an eligible line
   // ST_REQ     | irq_req high, irq_id frozen, waiting for ack or withdrawal
   // ST_SERVICE | core is servicing irq_id, no nesting, waiting for eoi

   logic [IRQ_LINES-1:0] src_s;
   logic [IRQ_LINES-1:0] src_q;
   logic [IRQ_LINES-1:0] pend_q, pend_d;
   logic [IRQ_LINES-1:0] en_q, en_d;
   logic [IRQ_LINES-1:0] edge_q, edge_d;
   irq_state_e           state_q, state_d;
   logic [ID_W-1:0]      irq_id_q, irq_id_d;

   logic [IRQ_LINES-1:0] eligible;
   logic [IRQ_LINES-1:0] sel_mask;
   logic [IRQ_LINES-1:0] w1c_mask;
   logic [IRQ_LINES-1:0] ack_mask;
   logic [IRQ_LINES-1:0] rise;
   logic                 enc_valid;
   logic [ID_W-1:0]      enc_idx;
   logic                 in_service;
   logic [ID_W+1:0]      status_raw;

`ifdef IRQ_SYNC_EN
   logic [IRQ_LINES-1:0] sync1_q, sync2_q;

   // Two-stage synchronizer on the raw event lines.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= src;
         sync2_q <= sync1_q;
      end
   end

   assign src_s = sync2_q;
`else
   assign src_s = src;
`endif

   irq_prio_enc #(
      .IRQ_LINES (IRQ_LINES),
      .ID_W      (ID_W)
   ) u_prio_enc (
      .req_i       (eligible),
      .any_valid_o (enc_valid),
      .idx_o       (enc_idx)
   );

   assign eligible   = pend_q & en_q;
   assign rise       = src_s & ~src_q;
   assign irq_req    = (state_q == ST_REQ);
   assign in_service = (state_q == ST_SERVICE);
   assign irq_id     = irq_id_q;

   // Pending/enable/edge next-state; on an edge line a new rising edge beats a same-cycle clear.
   always_comb begin
      sel_mask = '0;
      for (int i = 0; i < IRQ_LINES; i++) begin
         sel_mask[i] = (irq_id_q == ID_W'(i));
      end
      w1c_mask = (cfg_we && cfg_addr == REG_PENDING) ? cfg_wdata : '0;
      ack_mask = (state_q == ST_REQ && irq_ack) ? sel_mask : '0;
      pend_d   = (edge_q & ((pend_q & ~(w1c_mask | ack_mask)) | rise))
               | (~edge_q & src_s);
      en_d     = (cfg_we && cfg_addr == REG_ENABLE) ? cfg_wdata : en_q;
      edge_d   = (cfg_we && cfg_addr == REG_EDGE)   ? cfg_wdata : edge_q;
   end

   // Request/claim/complete sequencing.
   always_comb begin
      state_d  = state_q;
      irq_id_d = irq_id_q;
      unique case (state_q)
         ST_IDLE: begin
            if (enc_valid) begin
               state_d  = ST_REQ;
               irq_id_d = enc_idx;
            end
         end
         ST_REQ: begin
            if (irq_ack)                          state_d = ST_SERVICE;
            else if ((eligible & sel_mask) == '0) state_d = ST_IDLE;
         end
         ST_SERVICE: begin
            if (irq_eoi) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // All controller state, cleared asynchronously.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         src_q    <= '0;
         pend_q   <= '0;
         en_q     <= '0;
         edge_q   <= '0;
         state_q  <= ST_IDLE;
         irq_id_q <= '0;
      end else begin
         src_q    <= src_s;
         pend_q   <= pend_d;
         en_q     <= en_d;
         edge_q   <= edge_d;
         state_q  <= state_d;
         irq_id_q <= irq_id_d;
      end
   end

   // Combinational register read-back; STATUS is truncated/padded to IRQ_LINES bits.
   always_comb begin
      status_raw                          = '0;
      status_raw[ID_W-1:0]                = irq_id_q;
      status_raw[ID_W + STAT_REQ_REL]     = irq_req;
      status_raw[ID_W + STAT_INSVC_REL]   = in_service;
      cfg_rdata                           = '0;
      unique case (cfg_addr)
         REG_PENDING: cfg_rdata = pend_q;
         REG_ENABLE:  cfg_rdata = en_q;
         REG_EDGE:    cfg_rdata = edge_q;
         REG_STATUS:  cfg_rdata = IRQ_LINES'(status_raw);
         default:     cfg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl_ad48.sv
// Scoreboard bench for irq_ctrl_ad48 (IRQ_LINES=4, ID_W=2 so STATUS shows all fields).
module tb_irq_ctrl_ad48;
   import irq_ad48_pkg::*;

   localparam int N  = 4;
   localparam int IW = 2;
`ifdef IRQ_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif
   localparam int SD = LAT - 2;

   logic          clk = 1'b0;
   logic          resetn;
   logic [N-1:0]  src;
   logic          cfg_we;
   logic [1:0]    cfg_addr;
   logic [N-1:0]  cfg_wdata;
   logic [N-1:0]  cfg_rdata;
   logic          irq_req;
   logic [IW-1:0] irq_id;
   logic          irq_ack;
   logic          irq_eoi;

   irq_ctrl_ad48 #(.IRQ_LINES(N), .ID_W(IW)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .src       (src),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_rdata (cfg_rdata),
      .irq_req   (irq_req),
      .irq_id    (irq_id),
      .irq_ack   (irq_ack),
      .irq_eoi   (irq_eoi)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         due;
      int         kind;   // 0 irq_req, 1 irq_id, 2 cfg_rdata
      logic [7:0] exp;
      string      name;
   } chk_t;

   chk_t       sb[$];
   int         cyc     = 0;
   int         n_pass  = 0;
   int         n_total = 0;
   logic [7:0] mon_act;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_exp(input int kind, input logic [7:0] exp, input int dly, input string name);
      chk_t c;
      c.due  = cyc + dly;
      c.kind = kind;
      c.exp  = exp;
      c.name = name;
      sb.push_back(c);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [N-1:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      step(1);
      cfg_we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string name);
      cfg_addr = a;
      push_exp(2, exp, 0, name);
      step(1);
   endtask

   task automatic pulse(input logic [N-1:0] v);
      src = v;
      step(1);
      src = '0;
      step(LAT - 1);
   endtask

   task automatic do_ack();
      irq_ack = 1'b1; step(1); irq_ack = 1'b0;
   endtask

   task automatic do_eoi();
      irq_eoi = 1'b1; step(1); irq_eoi = 1'b0;
   endtask

   // Monitor: compares every due expectation against the DUT at the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
               case (sb[i].kind)
                  0:       mon_act = {7'd0, irq_req};
                  1:       mon_act = {6'd0, irq_id};
                  default: mon_act = {4'd0, cfg_rdata};
               endcase
               n_total++;
               if (sb[i].due == cyc && mon_act == sb[i].exp) n_pass++;
               else $display("FAIL %s: got %0h expected %0h (cycle %0d, due %0d)",
                             sb[i].name, mon_act, sb[i].exp, cyc, sb[i].due);
               sb.delete(i);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0; src = '0; cfg_we = 1'b0; cfg_addr = REG_PENDING;
      cfg_wdata = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
      step(2);
      n_total++;
      if (irq_req === 1'b0) n_pass++;
      else $display("FAIL rst_req_direct: got %0h expected 0", irq_req);
      push_exp(0, 8'h0, 0, "rst_req");
      push_exp(1, 8'h0, 0, "rst_id");
      step(1);
      resetn = 1'b1;
      step(1);
      rd(REG_PENDING, 8'h0, "rst_pending");
      rd(REG_ENABLE,  8'h0, "rst_enable");
      rd(REG_EDGE,    8'h0, "rst_edge");
      rd(REG_STATUS,  8'h0, "rst_status");

      // Edge basics
      wr(REG_EDGE, 4'hF);
      wr(REG_ENABLE, 4'h4);
      src = 4'b0100;
      step(1);
      src = '0;
      if (LAT > 2) step(LAT - 2);
      push_exp(0, 8'h0, 0, "edge_not_yet");
      step(1);
      push_exp(0, 8'h1, 0, "edge_req");
      push_exp(1, 8'h2, 0, "edge_id");
      rd(REG_PENDING, 8'h4, "edge_pending");
      rd(REG_STATUS,  8'h6, "edge_status_req");
      do_ack();
      push_exp(0, 8'h0, 0, "ack_req_low");
      rd(REG_PENDING, 8'h0, "ack_clears_pending");
      rd(REG_STATUS,  8'hA, "ack_in_service");
      do_eoi();
      rd(REG_STATUS,  8'h2, "eoi_idle_status");
      push_exp(0, 8'h0, 0, "eoi_no_rereq");

      // Priority
      wr(REG_ENABLE, 4'hF);
      pulse(4'b1010);
      push_exp(0, 8'h1, 0, "prio_req");
      push_exp(1, 8'h1, 0, "prio_id1");
      do_ack();
      rd(REG_PENDING, 8'h8, "prio_pending_left");
      do_eoi();
      push_exp(0, 8'h0, 0, "prio_eoi_req_low");
      step(1);
      push_exp(0, 8'h1, 0, "prio_next_req");
      push_exp(1, 8'h3, 0, "prio_id3");
      do_ack();
      do_eoi();

      // Withdrawal
      pulse(4'b0001);
      push_exp(1, 8'h0, 0, "wd_id0");
      push_exp(0, 8'h1, 0, "wd_req");
      wr(REG_ENABLE, 4'h0);
      step(1);
      push_exp(0, 8'h0, 0, "wd_req_low");
      rd(REG_PENDING, 8'h1, "wd_pending_kept");
      rd(REG_STATUS,  8'h0, "wd_status_idle");
      wr(REG_PENDING, 4'hF);
      rd(REG_PENDING, 8'h0, "wd_w1c");

      // Level line
      wr(REG_EDGE, 4'h0);
      wr(REG_ENABLE, 4'h1);
      src = 4'b0001;
      step(LAT);
      push_exp(0, 8'h1, 0, "lvl_req");
      push_exp(1, 8'h0, 0, "lvl_id");
      do_ack();
      push_exp(0, 8'h0, 0, "lvl_ack_req_low");
      rd(REG_STATUS, 8'h8, "lvl_in_service");
      do_eoi();
      push_exp(0, 8'h0, 0, "lvl_eoi_req_low");
      step(1);
      push_exp(0, 8'h1, 0, "lvl_rereq");
      do_ack();
      wr(REG_PENDING, 4'h1);
      rd(REG_PENDING, 8'h1, "lvl_w1c_ignored");
      src = '0;
      step(1 + SD);
      rd(REG_PENDING, 8'h0, "lvl_drop");
      do_eoi();
      step(1);
      push_exp(0, 8'h0, 0, "lvl_no_req");

      // Conflicts
      wr(REG_EDGE, 4'hF);
      wr(REG_ENABLE, 4'h0);
      src = 4'b0010;
      repeat (SD) begin
         step(1);
         src = '0;
      end
      cfg_we = 1'b1; cfg_addr = REG_PENDING; cfg_wdata = 4'b0010;
      step(1);
      cfg_we = 1'b0; src = '0;
      rd(REG_PENDING, 8'h2, "set_wins_w1c");
      wr(REG_PENDING, 4'b0010);
      rd(REG_PENDING, 8'h0, "w1c_edge");
      do_eoi();
      rd(REG_STATUS, 8'h0, "eoi_in_idle");
      wr(REG_ENABLE, 4'h2);
      pulse(4'b0010);
      do_ack();
      do_ack();
      rd(REG_STATUS, 8'h9, "ack_in_service_ignored");
      do_eoi();
      rd(REG_STATUS, 8'h1, "conf_eoi_done");

      // Async reset mid-SERVICE
      pulse(4'b1010);
      do_ack();
      rd(REG_STATUS, 8'h9, "pre_rst_service");
      cfg_addr = REG_STATUS;
      resetn = 1'b0;
      #1;
      n_total++;
      if (irq_req === 1'b0) n_pass++;
      else $display("FAIL arst_req_direct: got %0h expected 0", irq_req);
      n_total++;
      if (irq_id === '0) n_pass++;
      else $display("FAIL arst_id_direct: got %0h expected 0", irq_id);
      n_total++;
      if (cfg_rdata === '0) n_pass++;
      else $display("FAIL arst_status_direct: got %0h expected 0", cfg_rdata);
      push_exp(0, 8'h0, 0, "arst_req");
      push_exp(1, 8'h0, 0, "arst_id");
      push_exp(2, 8'h0, 0, "arst_status");
      step(1);
      rd(REG_PENDING, 8'h0, "arst_pending");
      rd(REG_ENABLE,  8'h0, "arst_enable");
      rd(REG_EDGE,    8'h0, "arst_edge");
      resetn = 1'b1;
      step(2);

      for (int i = 0; i < sb.size(); i++) begin
         n_total++;
         $display("FAIL %s: got unchecked expected checked (due %0d)", sb[i].name, sb[i].due);
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
